// File: rtl/axil_cmd_master.sv
// axil_cmd_master: turns single cmd/rsp transactions into AXI-Lite reads and writes, with a per-handshake timeout
module axil_cmd_master #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk_main_a0,
  input  logic        rst_main_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        bvalid,
  input  logic [1:0]  bresp,
  output logic        bready,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  input  logic        rvalid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  output logic        rready,
  output logic [15:0] txn_count,
  output logic [15:0] err_count
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;
  state_t      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic        arvalid_q, arvalid_d, rready_q, rready_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_resp_q, rsp_resp_d;
  logic [15:0] tmo_q, tmo_d, txn_q, txn_d, err_q, err_d;
  logic        waiting;
  assign cmd_ready   = cmd_ready_q;
  assign awvalid     = awvalid_q;
  assign awaddr      = addr_q;
  assign wvalid      = wvalid_q;
  assign wdata       = wdata_q;
  assign wstrb       = wstrb_q;
  assign bready      = bready_q;
  assign arvalid     = arvalid_q;
  assign araddr      = addr_q;
  assign rready      = rready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;
  assign txn_count   = txn_q;
  assign err_count   = err_q;
  assign waiting     = state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA};
  // state and every output register; reset abandons any transaction in flight
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
      tmo_q         <= '0;
      txn_q         <= '0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      tmo_q         <= tmo_d;
      txn_q         <= txn_d;
      err_q         <= err_d;
    end
  end
  // next state and next output values; a timeout overrides whatever the current state wanted
  always_comb begin
    state_d       = state_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    txn_d         = txn_q;
    err_d         = err_q;
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready_q) begin
        addr_d    = cmd_addr;
        wdata_d   = cmd_wdata;
        wstrb_d   = cmd_wstrb;
        awvalid_d = cmd_write;
        wvalid_d  = cmd_write;
        arvalid_d = !cmd_write;
        state_d   = cmd_write ? WR_REQ : RD_REQ;
      end
      WR_REQ: begin
        awvalid_d = awvalid_q && !awready;
        wvalid_d  = wvalid_q && !wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: if (bvalid && bready_q) begin
        bready_d      = 1'b0;
        rsp_valid_d   = 1'b1;
        rsp_rdata_d   = '0;
        rsp_resp_d    = bresp;
        rsp_timeout_d = 1'b0;
        state_d       = RSP;
      end
      RD_REQ: if (arready) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = RD_DATA;
      end
      RD_DATA: if (rvalid && rready_q) begin
        rready_d      = 1'b0;
        rsp_valid_d   = 1'b1;
        rsp_rdata_d   = rdata;
        rsp_resp_d    = rresp;
        rsp_timeout_d = 1'b0;
        state_d       = RSP;
      end
      RSP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        txn_d       = txn_q + 16'd1;
        err_d       = (rsp_resp_q != 2'b00 || rsp_timeout_q) ? err_q + 16'd1 : err_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (waiting && tmo_q == 16'(TIMEOUT - 1)) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_resp_d    = 2'b10;
      rsp_timeout_d = 1'b1;
      state_d       = RSP;
    end
    tmo_d       = (state_d != state_q || !waiting) ? 16'd0 : tmo_q + 16'd1;
    cmd_ready_d = (state_d == IDLE);
  end
endmodule

// File: tb/tb_axil_cmd_master.sv
// tb_axil_cmd_master: directed checks of the AXI-Lite command master against a configurable slave model
module tb_axil_cmd_master;
  logic        clk_main_a0 = 1'b0;
  logic        rst_main_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [15:0] txn_count, err_count;
  int tests = 0;
  int fails = 0;
  int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_cnt, w_cnt, ar_cnt, r_wait, b_count;
  logic r_pend, aw_seen, w_seen, b_hold = 1'b0;
  logic [1:0]  bresp_v = 2'b00, rresp_v = 2'b00;
  logic [31:0] rdata_v = '0;

  always #5 clk_main_a0 = ~clk_main_a0;

  axil_cmd_master #(.TIMEOUT(8)) dut (
    .clk_main_a0(clk_main_a0), .rst_main_n(rst_main_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
    .txn_count(txn_count), .err_count(err_count)
  );

  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid && (w_cnt >= w_dly);
  assign arready = arvalid && (ar_cnt >= ar_dly);
  assign bresp   = bresp_v;
  assign rresp   = rresp_v;
  assign rdata   = rdata_v;

  // slave model: readies after a per-channel wait, B once both AW and W are done, R after r_dly cycles
  always @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_wait <= 0; b_count <= 0;
      r_pend <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      if (bvalid && bready) begin
        bvalid <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0; b_count <= b_count + 1;
      end else begin
        if (awvalid && awready) aw_seen <= 1'b1;
        if (wvalid && wready) w_seen <= 1'b1;
        if (!bvalid && !b_hold && (aw_seen || (awvalid && awready)) && (w_seen || (wvalid && wready)))
          bvalid <= 1'b1;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      else if (arvalid && arready) begin
        if (r_dly == 0) rvalid <= 1'b1;
        else begin r_pend <= 1'b1; r_wait <= 1; end
      end else if (r_pend) begin
        if (r_wait >= r_dly) begin rvalid <= 1'b1; r_pend <= 1'b0; end
        else r_wait <= r_wait + 1;
      end
    end
  end

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int i;
    for (i = 0; i < 20 && !cmd_ready; i++) @(negedge clk_main_a0);
    tests++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL cmd_ready_wait: got %b expected 1", cmd_ready); end
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge clk_main_a0);
    cmd_valid = 1'b0; cmd_addr = 32'hFFFF_FFFF; cmd_wdata = 32'hFFFF_FFFF; cmd_wstrb = 4'h0;
  endtask

  task automatic wait_rsp(input int start, output int n);
    n = start;
    while (!rsp_valid && n < 60) begin @(negedge clk_main_a0); n++; end
    if (!rsp_valid) n = -1;
  endtask

  task automatic test_reset;
    rst_main_n = 1'b0;
    @(negedge clk_main_a0);
    @(negedge clk_main_a0);
    tests++;
    if ({cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 7'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 0", {cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid});
    end
    tests++;
    if ({txn_count, err_count, rsp_resp, rsp_timeout, rsp_rdata, awaddr} !== '0) begin
      fails++; $display("FAIL reset_data: got txn=%h err=%h rdata=%h awaddr=%h expected 0", txn_count, err_count, rsp_rdata, awaddr);
    end
    rst_main_n = 1'b1;
    @(negedge clk_main_a0);
    tests++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_write_zero_wait;
    int n;
    send_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    tests++;
    if ({awvalid, wvalid, cmd_ready} !== 3'b110) begin
      fails++; $display("FAIL wr_valids_n1: got aw=%b w=%b rdy=%b expected 1 1 0", awvalid, wvalid, cmd_ready);
    end
    tests++;
    if (awaddr !== 32'h10 || wdata !== 32'hDEADBEEF || wstrb !== 4'hF) begin
      fails++; $display("FAIL wr_fields: got %h %h %h expected 10 deadbeef f", awaddr, wdata, wstrb);
    end
    wait_rsp(1, n);
    tests++;
    if (n !== 3) begin fails++; $display("FAIL wr_latency: got %0d expected 3", n); end
    tests++;
    if (rsp_resp !== 2'b00 || rsp_rdata !== 32'h0 || rsp_timeout !== 1'b0) begin
      fails++; $display("FAIL wr_rsp: got resp=%b rdata=%h to=%b expected 00 0 0", rsp_resp, rsp_rdata, rsp_timeout);
    end
    @(negedge clk_main_a0);
    tests++;
    if (txn_count !== 16'd1 || cmd_ready !== 1'b1) begin
      fails++; $display("FAIL wr_txn: got txn=%0d rdy=%b expected 1 1", txn_count, cmd_ready);
    end
  endtask

  task automatic test_aw_delay;
    int aw_hi = 0, w_hi = 0, n = 1, b0;
    aw_dly = 4;
    b0 = b_count;
    send_cmd(1'b1, 32'h44, 32'h0BAD_F00D, 4'h3);
    while (!rsp_valid && n < 60) begin
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      @(negedge clk_main_a0); n++;
    end
    tests++;
    if (aw_hi !== 5) begin fails++; $display("FAIL awdly_aw_cycles: got %0d expected 5", aw_hi); end
    tests++;
    if (w_hi !== 1) begin fails++; $display("FAIL awdly_w_cycles: got %0d expected 1", w_hi); end
    repeat (3) @(negedge clk_main_a0);
    tests++;
    if (b_count - b0 !== 1) begin fails++; $display("FAIL awdly_b_count: got %0d expected 1", b_count - b0); end
    tests++;
    if (txn_count !== 16'd2) begin fails++; $display("FAIL awdly_txn: got %0d expected 2", txn_count); end
    aw_dly = 0;
  endtask

  task automatic test_read_zero_wait;
    int n;
    rdata_v = 32'hA5A5_0001;
    send_cmd(1'b0, 32'h30, 32'h0, 4'h0);
    tests++;
    if (arvalid !== 1'b1 || awvalid !== 1'b0 || araddr !== 32'h30) begin
      fails++; $display("FAIL rd0_ar: got ar=%b aw=%b addr=%h expected 1 0 30", arvalid, awvalid, araddr);
    end
    wait_rsp(1, n);
    tests++;
    if (n !== 3) begin fails++; $display("FAIL rd0_latency: got %0d expected 3", n); end
    tests++;
    if (rsp_rdata !== 32'hA5A5_0001) begin fails++; $display("FAIL rd0_data: got %h expected a5a50001", rsp_rdata); end
    @(negedge clk_main_a0);
  endtask

  task automatic test_read_wait;
    int n;
    r_dly = 2; rdata_v = 32'h12345678;
    send_cmd(1'b0, 32'h20, 32'h0, 4'h0);
    wait_rsp(1, n);
    tests++;
    if (n !== 5) begin fails++; $display("FAIL rd_latency: got %0d expected 5", n); end
    tests++;
    if (rsp_rdata !== 32'h12345678 || rsp_timeout !== 1'b0 || rsp_resp !== 2'b00) begin
      fails++; $display("FAIL rd_rsp: got rdata=%h to=%b resp=%b expected 12345678 0 00", rsp_rdata, rsp_timeout, rsp_resp);
    end
    @(negedge clk_main_a0);
    tests++;
    if (txn_count !== 16'd4 || err_count !== 16'd0) begin
      fails++; $display("FAIL rd_counts: got txn=%0d err=%0d expected 4 0", txn_count, err_count);
    end
    r_dly = 0;
  endtask

  task automatic test_timeout;
    int ar_hi = 0, n = 1;
    ar_dly = 1000;
    send_cmd(1'b0, 32'h80, 32'h0, 4'h0);
    while (!rsp_valid && n < 60) begin
      if (arvalid) ar_hi++;
      @(negedge clk_main_a0); n++;
    end
    tests++;
    if (ar_hi !== 8) begin fails++; $display("FAIL tmo_ar_cycles: got %0d expected 8", ar_hi); end
    tests++;
    if (arvalid !== 1'b0 || rready !== 1'b0) begin fails++; $display("FAIL tmo_drop: got ar=%b r=%b expected 0 0", arvalid, rready); end
    tests++;
    if (rsp_resp !== 2'b10 || rsp_timeout !== 1'b1) begin
      fails++; $display("FAIL tmo_rsp: got resp=%b to=%b expected 10 1", rsp_resp, rsp_timeout);
    end
    @(negedge clk_main_a0);
    tests++;
    if (err_count !== 16'd1 || txn_count !== 16'd5) begin
      fails++; $display("FAIL tmo_counts: got err=%0d txn=%0d expected 1 5", err_count, txn_count);
    end
    ar_dly = 0;
  endtask

  task automatic test_bresp_backpressure;
    int n;
    rst_main_n = 1'b0;
    @(negedge clk_main_a0);
    rst_main_n = 1'b1;
    @(negedge clk_main_a0);
    bresp_v = 2'b10; rsp_ready = 1'b0;
    send_cmd(1'b1, 32'h54, 32'h1111_2222, 4'h5);
    wait_rsp(1, n);
    tests++;
    if (n !== 3) begin fails++; $display("FAIL bp_latency: got %0d expected 3", n); end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_main_a0);
      tests++;
      if ({rsp_valid, rsp_resp, rsp_timeout, cmd_ready} !== 5'b1_10_0_0 || rsp_rdata !== 32'h0) begin
        fails++; $display("FAIL bp_hold_%0d: got v=%b resp=%b to=%b rdy=%b rdata=%h expected 1 10 0 0 0", i, rsp_valid, rsp_resp, rsp_timeout, cmd_ready, rsp_rdata);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk_main_a0);
    tests++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin fails++; $display("FAIL bp_release: got v=%b rdy=%b expected 0 1", rsp_valid, cmd_ready); end
    tests++;
    if (err_count !== 16'd1 || txn_count !== 16'd1) begin
      fails++; $display("FAIL bp_counts: got err=%0d txn=%0d expected 1 1", err_count, txn_count);
    end
    bresp_v = 2'b00;
  endtask

  task automatic test_reset_mid_txn;
    b_hold = 1'b1;
    send_cmd(1'b1, 32'h60, 32'hCAFE_0000, 4'hF);
    @(negedge clk_main_a0);
    tests++;
    if (bready !== 1'b1) begin fails++; $display("FAIL mid_in_wr_resp: got bready=%b expected 1", bready); end
    #2 rst_main_n = 1'b0;
    #1;
    tests++;
    if ({cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 7'b0) begin
      fails++; $display("FAIL mid_ctrl: got %b expected 0", {cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid});
    end
    tests++;
    if ({awaddr, wdata, wstrb, txn_count, err_count} !== '0) begin
      fails++; $display("FAIL mid_data: got awaddr=%h wdata=%h txn=%0d err=%0d expected 0", awaddr, wdata, txn_count, err_count);
    end
    @(negedge clk_main_a0);
    b_hold = 1'b0;
    rst_main_n = 1'b1;
    @(negedge clk_main_a0);
    tests++;
    if (cmd_ready !== 1'b1 || txn_count !== 16'd0) begin
      fails++; $display("FAIL mid_release: got rdy=%b txn=%0d expected 1 0", cmd_ready, txn_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_main_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;
    test_reset();
    test_write_zero_wait();
    test_aw_delay();
    test_read_zero_wait();
    test_read_wait();
    test_timeout();
    test_bresp_backpressure();
    test_reset_mid_txn();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024, meaning the number of cycles to wait for any single AXI handshake before aborting; the legal range is 2..65535.
REQ-002 SHALL have port clk_main_a0, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_main_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid, input, 1: command present.
REQ-005 SHALL have port cmd_ready, output, 1: command accepted when high together with cmd_valid.
REQ-006 SHALL have port cmd_write, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have ports cmd_addr, input, 32 bits; cmd_wdata, input, 32 bits; cmd_wstrb, input, 4 bits.
REQ-008 SHALL have ports rsp_valid, output, 1; and rsp_ready, input, 1: the response handshake.
REQ-009 SHALL have ports rsp_rdata, output, 32 bits; rsp_resp, output, 2 bits; rsp_timeout, output, 1.
REQ-010 SHALL have the AXI-Lite master write channels: awvalid/awready (out/in, 1), awaddr (out, 32), wvalid/wready (out/in, 1), wdata (out, 32), wstrb (out, 4), bvalid (in, 1), bresp (in, 2), bready (out, 1).
REQ-011 SHALL have the AXI-Lite master read channels: arvalid/arready (out/in, 1), araddr (out, 32), rvalid (in, 1), rdata (in, 32), rresp (in, 2), rready (out, 1).
REQ-012 SHALL have ports txn_count and err_count, outputs, 16 bits each: completed transactions and errored transactions.

Function
REQ-013 SHALL implement the states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA and RSP; every AXI and rsp output SHALL be driven from a register.
REQ-014 SHALL drive cmd_ready high only in IDLE; on acceptance it SHALL latch addr, wdata and wstrb and go to WR_REQ (write) or RD_REQ (read).
REQ-015 SHALL, in WR_REQ, assert awvalid and wvalid together starting the cycle after acceptance.
REQ-016 SHALL drop each of awvalid and wvalid independently the cycle after its own ready is sampled high, and SHALL keep it asserted otherwise.
REQ-017 SHALL move from WR_REQ to WR_RESP once both the AW and W handshakes have completed, including when both complete in the same cycle.
REQ-018 SHALL, in WR_RESP, hold bready high and capture bresp on bvalid, then go to RSP; rsp_rdata SHALL be 0 for writes.
REQ-019 SHALL, in RD_REQ, hold arvalid until arready, then enter RD_DATA.
REQ-020 SHALL, in RD_DATA, hold rready high and capture rdata and rresp on rvalid, then go to RSP.
REQ-021 SHALL hold rsp_valid high in RSP with the response fields stable until rsp_ready, then return to IDLE; no new command is accepted while in RSP.
REQ-022 SHALL achieve, with a zero-wait slave, rsp_valid 3 cycles after the cmd-accept edge for both writes and reads.
REQ-023 SHALL clear a 16-bit timeout counter on each state entry and increment it every cycle spent in WR_REQ, WR_RESP, RD_REQ or RD_DATA.
REQ-024 SHALL, when the timeout counter reaches TIMEOUT-1, drop all AXI valids and readies on the next edge, enter RSP with rsp_resp=2'b10 and rsp_timeout=1, and SHALL ignore any later stray bvalid or rvalid; this is recovery only.
REQ-025 SHALL increment txn_count by 1 on each RSP handshake, wrapping from 16'hFFFF to 0.
REQ-026 SHALL increment err_count, wrapping, on each RSP handshake where rsp_resp is not 0 or rsp_timeout is 1.
REQ-027 SHALL leave awaddr, araddr, wdata and wstrb holding the latched command values and ignore cmd_* inputs outside IDLE.

Reset
REQ-028 SHALL, on rst_main_n low, asynchronously force state to IDLE, all valids and readies (except cmd_ready) to 0, cmd_ready to 0, all data, address and resp outputs to 0, and both counters to 0.
REQ-029 SHALL raise cmd_ready on the first clock edge after rst_main_n deasserts.
REQ-030 SHALL, on reset mid-transaction, abandon the transaction with no response, leave the counters at 0, and deassert all AXI valids in the same cycle the reset asserts.

Verification
REQ-031 SHALL pass: write addr=0x10, data=0xDEADBEEF, strb=0xF against a zero-wait slave -> awvalid and wvalid seen 1 cycle after accept; rsp_valid 3 cycles after accept; rsp_resp=0; txn_count=1.
REQ-032 SHALL pass: write with awready delayed 4 cycles and wready immediate -> wvalid high exactly 1 cycle, awvalid high 5 cycles; a single B handshake follows.
REQ-033 SHALL pass: read addr=0x20 where the slave returns rdata=0x12345678, rresp=0 after 2 wait cycles -> rsp_rdata=0x12345678, rsp_timeout=0.
REQ-034 SHALL pass: read where arready is never asserted and TIMEOUT=8 -> arvalid drops after 8 cycles; rsp_resp=2'b10, rsp_timeout=1, err_count=1.
REQ-035 SHALL pass: slave returns bresp=2'b10 and rsp_ready is held low for 5 cycles -> rsp fields remain stable; cmd_ready stays 0 until the handshake; err_count=1.
REQ-036 SHALL pass: rst_main_n pulsed low during WR_RESP -> all outputs 0 immediately; cmd_ready=1 one edge after release; txn_count=0.
